// File: rtl/apb_periph_router_pkg.sv
// Shared types and constants for the APB peripheral router: FSM encoding,
// slot-index width and the default error read-data pattern.
package apb_periph_router_pkg;

  localparam int IDX_W = 4;
  localparam logic [31:0] ERR_DATA_DEF = 32'hBADC_AB1E;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/apb_periph_router_if.sv
// Bus bundle for the router: upstream APB port from the bridge plus the
// fanned-out downstream APB port to the peripheral slots.
interface apb_periph_router_if #(
  parameter int NSLV = 10,
  parameter int DW   = 32,
  parameter int AW   = 32
);
  logic              psel_i;
  logic              penable_i;
  logic [AW-1:0]     paddr_i;
  logic              pwrite_i;
  logic [DW-1:0]     pwdata_i;
  logic [DW-1:0]     prdata_o;
  logic              pready_o;
  logic              pslverr_o;
  logic [NSLV-1:0]   psel_o;
  logic              penable_o;
  logic [AW-1:0]     paddr_o;
  logic              pwrite_o;
  logic [DW-1:0]     pwdata_o;
  logic [NSLV*DW-1:0] prdata_i;
  logic [NSLV-1:0]   pready_i;
  logic [NSLV-1:0]   pslverr_i;
  logic              timeout_o;

  modport slave (
    input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
    input  prdata_i, pready_i, pslverr_i,
    output prdata_o, pready_o, pslverr_o,
    output psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, timeout_o
  );

  modport master (
    output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
    output prdata_i, pready_i, pslverr_i,
    input  prdata_o, pready_o, pslverr_o,
    input  psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, timeout_o
  );
endinterface

// File: rtl/apb_slot_decode.sv
// Combinational slot decoder: splits PADDR into a 4-bit slot index and
// flags a hit when the address falls in the window and the slot exists.
module apb_slot_decode
  import apb_periph_router_pkg::*;
#(
  parameter int            AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = 32'h1A10_0000,
  parameter int            SLOT_BITS = 12,
  parameter int            NSLV      = 10
) (
  input  logic [AW-1:0]    paddr,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);

  logic unused_low;

  assign idx = paddr[SLOT_BITS+IDX_W-1:SLOT_BITS];
  assign hit = (paddr[AW-1:SLOT_BITS+IDX_W] == BASE_ADDR[AW-1:SLOT_BITS+IDX_W])
            && (int'(idx) < NSLV);

  // Byte offset within a slot plays no part in routing.
  assign unused_low = ^paddr[SLOT_BITS-1:0];

endmodule

// File: rtl/apb_periph_router.sv
// APB 1-to-NSLV router: registers the upstream transfer, replays it to the
// decoded slot and answers upstream, erroring out unmapped or stuck accesses.
module apb_periph_router
  import apb_periph_router_pkg::*;
#(
  parameter int            NSLV      = 10,
  parameter int            DW        = 32,
  parameter int            AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = 32'h1A10_0000,
  parameter int            SLOT_BITS = 12,
  parameter int            TIMEOUT   = 256,
  parameter logic [DW-1:0] ERR_DATA  = DW'(ERR_DATA_DEF)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  apb_periph_router_if.slave bus
);

  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               TO_EN    = (TIMEOUT != 0);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx_dec;
  logic             hit_dec;
  logic [AW-1:0]    addr_p0;
  logic [DW-1:0]    wdata_p0;
  logic             write_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    rdata_p1;
  logic             err_p1;
  logic [DW-1:0]    slot_rdata;
  logic             slot_ready;
  logic             slot_err;
  logic [NSLV-1:0]  sel_vec;
  logic             cap;
  logic             acc_ok;
  logic             acc_to;

  apb_slot_decode #(
    .AW        (AW),
    .BASE_ADDR (BASE_ADDR),
    .SLOT_BITS (SLOT_BITS),
    .NSLV      (NSLV)
  ) u_decode (
    .paddr (bus.paddr_i),
    .idx   (idx_dec),
    .hit   (hit_dec)
  );

  // Only the captured slot is looked at; every other slave is ignored.
  always_comb begin
    slot_rdata = '0;
    slot_ready = 1'b0;
    slot_err   = 1'b0;
    sel_vec    = '0;
    for (int n = 0; n < NSLV; n++) begin
      if (idx_p0 == IDX_W'(n)) begin
        slot_rdata = bus.prdata_i[n*DW +: DW];
        slot_ready = bus.pready_i[n];
        slot_err   = bus.pslverr_i[n];
        sel_vec[n] = 1'b1;
      end
    end
  end

  always_comb begin
    state_n       = state;
    cap           = 1'b0;
    acc_ok        = 1'b0;
    acc_to        = 1'b0;
    bus.psel_o    = '0;
    bus.penable_o = 1'b0;
    bus.pready_o  = 1'b0;
    bus.pslverr_o = 1'b0;
    bus.prdata_o  = '0;
    bus.timeout_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.psel_i && !bus.penable_i) begin
          cap     = 1'b1;
          state_n = hit_dec ? SETUP : DONE;
        end
      end
      SETUP: begin
        bus.psel_o = sel_vec;
        state_n    = ACCESS;
      end
      ACCESS: begin
        bus.psel_o    = sel_vec;
        bus.penable_o = 1'b1;
        // A ready slave on the last allowed cycle still wins over the timeout.
        if (slot_ready) begin
          acc_ok  = 1'b1;
          state_n = DONE;
        end else if (TO_EN && (cnt == CNT_LAST)) begin
          acc_to        = 1'b1;
          bus.timeout_o = 1'b1;
          state_n       = DONE;
        end
      end
      DONE: begin
        bus.pready_o  = 1'b1;
        bus.pslverr_o = err_p1;
        bus.prdata_o  = rdata_p1;
        state_n       = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage p0: request capture, FSM state and ACCESS cycle counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      write_p0 <= 1'b0;
      idx_p0   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state == ACCESS) ? cnt + CNT_W'(1) : '0;
      if (cap) begin
        addr_p0  <= bus.paddr_i;
        wdata_p0 <= bus.pwdata_i;
        write_p0 <= bus.pwrite_i;
        idx_p0   <= idx_dec;
      end
    end
  end

  // Stage p1: response capture, only ever observed in DONE
  always_ff @(posedge clk_i) begin
    if (cap && !hit_dec) begin
      rdata_p1 <= ERR_DATA;
      err_p1   <= 1'b1;
    end else if (acc_ok) begin
      rdata_p1 <= write_p0 ? '0 : slot_rdata;
      err_p1   <= slot_err;
    end else if (acc_to) begin
      rdata_p1 <= ERR_DATA;
      err_p1   <= 1'b1;
    end
  end

  assign bus.paddr_o  = addr_p0;
  assign bus.pwdata_o = wdata_p0;
  assign bus.pwrite_o = write_p0;

endmodule

// File: tb/tb_apb_periph_router.sv
// Scoreboard bench for apb_periph_router: behavioural slaves per slot, an
// upstream APB driver pushing expected responses, and a response monitor.
module tb_apb_periph_router;

  localparam int          NSLV    = 10;
  localparam int          DW      = 32;
  localparam int          AW      = 32;
  localparam int          TIMEOUT = 256;
  localparam logic [31:0] ERRD    = 32'hBADC_AB1E;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_periph_router_if #(.NSLV(NSLV), .DW(DW), .AW(AW)) bus ();

  apb_periph_router #(
    .NSLV      (NSLV),
    .DW        (DW),
    .AW        (AW),
    .BASE_ADDR (32'h1A10_0000),
    .SLOT_BITS (12),
    .TIMEOUT   (TIMEOUT),
    .ERR_DATA  (ERRD)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  exp_t        sb[$];
  bit          to_seen = 1'b0;
  int          slv_wait [NSLV];
  logic [31:0] slv_data [NSLV];
  logic        slv_err  [NSLV];
  int          acc_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Slaves: selected slot answers after slv_wait ACCESS cycles; unselected
  // slots drive ready/error permanently high so any leak shows up.
  always @(posedge clk) acc_cnt <= bus.penable_o ? acc_cnt + 1 : 0;

  always_comb begin
    for (int n = 0; n < NSLV; n++) begin
      bus.prdata_i[n*DW +: DW] = slv_data[n];
      bus.pready_i[n]  = bus.psel_o[n] ? (bus.penable_o && (acc_cnt >= slv_wait[n])) : 1'b1;
      bus.pslverr_i[n] = bus.psel_o[n] ? slv_err[n] : 1'b1;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.pready_o) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 64'(1), 64'(0));
          end else begin
            e = sb.pop_front();
            check("rdata", 64'(bus.prdata_o), 64'(e.rdata));
            check("pslverr", 64'(bus.pslverr_o), 64'(e.err));
            check("timeout_pulse", 64'(to_seen), 64'(e.to));
          end
          to_seen = 1'b0;
        end
        if (bus.timeout_o) to_seen = 1'b1;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 with the upstream bus released.
  task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wd, input logic [NSLV-1:0] exp_psel,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input logic exp_to, input int exp_lat);
    int lat = 0;
    bit got = 1'b0;
    bus.psel_i    = 1'b1;
    bus.penable_i = 1'b0;
    bus.paddr_i   = addr;
    bus.pwrite_i  = wr;
    bus.pwdata_i  = wd;
    sb.push_back(exp_t'{exp_rd, exp_err, exp_to});
    @(posedge clk);
    #1 bus.penable_i = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      lat++;
      if (bus.pready_o) begin
        got = 1'b1;
        break;
      end
      check({tag, "_psel"}, 64'(bus.psel_o), 64'(exp_psel));
      check({tag, "_penable"}, 64'(bus.penable_o), 64'(lat >= 2));
      check({tag, "_prdata_idle"}, 64'(bus.prdata_o), 64'(0));
      if (exp_psel != '0) begin
        check({tag, "_paddr"}, 64'(bus.paddr_o), 64'(addr));
        check({tag, "_pwdata"}, 64'(bus.pwdata_o), 64'(wd));
        check({tag, "_pwrite"}, 64'(bus.pwrite_o), 64'(wr));
      end
    end
    check({tag, "_completed"}, 64'(got), 64'(1));
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_psel_done"}, 64'(bus.psel_o), 64'(0));
    check({tag, "_penable_done"}, 64'(bus.penable_o), 64'(0));
    @(posedge clk);
    #1;
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_psel"}, 64'(bus.psel_o), 64'(0));
    check({tag, "_penable"}, 64'(bus.penable_o), 64'(0));
    check({tag, "_pready"}, 64'(bus.pready_o), 64'(0));
    check({tag, "_pslverr"}, 64'(bus.pslverr_o), 64'(0));
    check({tag, "_prdata"}, 64'(bus.prdata_o), 64'(0));
    check({tag, "_timeout"}, 64'(bus.timeout_o), 64'(0));
    check({tag, "_paddr"}, 64'(bus.paddr_o), 64'(0));
    check({tag, "_pwdata"}, 64'(bus.pwdata_o), 64'(0));
    check({tag, "_pwrite"}, 64'(bus.pwrite_o), 64'(0));
  endtask

  initial begin
    for (int n = 0; n < NSLV; n++) begin
      slv_wait[n] = 0;
      slv_data[n] = 32'hA5A5_0000 | 32'(n);
      slv_err[n]  = 1'b0;
    end
    slv_data[3] = 32'h1234_5678;
    slv_wait[0] = 5;
    slv_data[0] = 32'h0BAD_0000;
    slv_wait[5] = 100000;
    slv_wait[6] = TIMEOUT - 1;
    slv_data[7] = 32'h7777_ABCD;
    slv_err[7]  = 1'b1;
    slv_data[1] = 32'h1111_2222;
    slv_wait[9] = 2;
    slv_wait[2] = 100000;
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
    bus.paddr_i   = '0;
    bus.pwrite_i  = 1'b0;
    bus.pwdata_i  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    xfer("rd3",    32'h1A10_3004, 1'b0, 32'h0,         10'h008, 32'h1234_5678, 1'b0, 1'b0, 3);
    xfer("wr0",    32'h1A10_0010, 1'b1, 32'hCAFE_F00D, 10'h001, 32'h0,         1'b0, 1'b0, 8);
    xfer("miss10", 32'h1A10_A000, 1'b0, 32'h0,         10'h000, ERRD,          1'b1, 1'b0, 1);
    xfer("miss2k", 32'h2000_0000, 1'b1, 32'h0000_0055, 10'h000, ERRD,          1'b1, 1'b0, 1);
    xfer("to5",    32'h1A10_5000, 1'b0, 32'h0,         10'h020, ERRD,          1'b1, 1'b1, 2 + TIMEOUT);
    xfer("edge6",  32'h1A10_6000, 1'b0, 32'h0,         10'h040, 32'hA5A5_0006, 1'b0, 1'b0, 2 + TIMEOUT);
    xfer("err7",   32'h1A10_7008, 1'b0, 32'h0,         10'h080, 32'h7777_ABCD, 1'b1, 1'b0, 3);
    xfer("rd1",    32'h1A10_1000, 1'b0, 32'h0,         10'h002, 32'h1111_2222, 1'b0, 1'b0, 3);
    xfer("rd9",    32'h1A10_9FFC, 1'b0, 32'h0,         10'h200, 32'hA5A5_0009, 1'b0, 1'b0, 5);

    // Reset in the middle of an ACCESS to a stalled slot 2.
    bus.psel_i    = 1'b1;
    bus.penable_i = 1'b0;
    bus.paddr_i   = 32'h1A10_2000;
    bus.pwrite_i  = 1'b0;
    @(posedge clk);
    #1 bus.penable_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pre_access", 64'(bus.penable_o), 64'(1));
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    rst         = 1'b0;
    slv_wait[2] = 0;
    xfer("rd2_post", 32'h1A10_2000, 1'b0, 32'h0, 10'h004, 32'hA5A5_0002, 1'b0, 1'b0, 3);

    repeat (2) @(posedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
